voice_scheduler: RTL and testbench
==================================

# voice_scheduler

Polyphonic voice allocator and envelope sequencer for the three-voice keyboard datapath. It consumes decoded key frames (three 8-bit key codes per SPI frame) and assigns each pressed key to one of three voice slots. It also runs a per-voice attack/hold/decay/release envelope and drives the per-voice key code, 8-bit gain and active voice count into the attenuation and mixing stages. It replaces free-running, never-reset envelope counters with per-voice envelopes that are sequenced from key events.

## Interface
Parameters:
- TICK_DIV, 400000: clk cycles per envelope tick (10 ms at 40 MHz).
- ATTACK_STEP, 5: gain increment per tick in ATTACK.
- HOLD_TICKS, 50: ticks spent at full gain.
- DECAY_STEP, 1: gain decrement per tick in DECAY.
- SUSTAIN_LVL, 64: DECAY floor while the key is held.
- RELEASE_STEP, 4: gain decrement per tick in RELEASE.

Ports (one clock; reset asynchronous, active-high):
- clk, in, 1: system clock.
- reset, in, 1: async active-high reset.
- frame_valid, in, 1: one-cycle strobe; frame_keys holds a new frame.
- frame_keys, in, 24: {key2,key1,key0}; key code 0 means no key.
- busy, out, 1: allocation FSM is not in S_IDLE.
- voice_note, out, 24: {v2,v1,v0} key code per voice; 0 when the voice is idle.
- voice_gain, out, 24: {g2,g1,g0} unsigned gain; 255 means full scale.
- voice_active, out, 3: voice state is not IDLE.
- voice_count, out, 2: popcount of voice_active.

## Operation
- Voice envelope states: IDLE, ATTACK, HOLD, DECAY, RELEASE. The envelope advances only on tick, a one-cycle pulse from a free-running divider that fires when the count reaches TICK_DIV-1 and then wraps to 0.
- ATTACK: gain = min(gain+ATTACK_STEP, 255). At 255 → HOLD and the hold counter is cleared.
- HOLD: hold counter increments; on tick HOLD_TICKS → DECAY.
- DECAY: gain = max(gain-DECAY_STEP, SUSTAIN_LVL). The voice stays in DECAY at the floor.
- RELEASE: gain = max(gain-RELEASE_STEP, 0). On reaching 0 → IDLE and the note is cleared to 0.
- All gain arithmetic uses 9-bit intermediates with saturation. Gain never wraps.
- Allocation FSM states: S_IDLE, S_REL, S_ALLOC0, S_ALLOC1, S_ALLOC2.
  - A frame_valid in S_IDLE latches frame_keys → S_REL.
  - A frame_valid while busy overwrites a one-deep pending register (latest frame wins). The pending frame is consumed on the return to S_IDLE.
- S_REL: every non-IDLE, non-RELEASE voice whose note is absent from the frame → RELEASE.
- S_ALLOCk handles key k:
  - Key 0, or a key equal to an earlier key in the same frame: no action.
  - Key held by a voice in ATTACK, HOLD or DECAY: no action.
  - Key held by a voice in RELEASE: that voice → ATTACK, keeping its current gain (retrigger).
  - Otherwise allocate the lowest-index IDLE voice: note = key, gain = 0, state ATTACK.
  - With no IDLE voice, see Configuration.
- Precedence: an allocation, release or retrigger write to a voice in a given cycle overrides that voice's tick update in the same cycle.

## Timing
- Reset values:
  - voice_note = 0, voice_gain = 0, voice_active = 0, voice_count = 0, busy = 0.
  - All voices IDLE; FSM S_IDLE; pending register empty; divider and hold counters 0.
- Reset asserted mid-frame aborts the frame and the pending frame. No partial allocation survives.
- frame_valid sampled at edge N:
  - busy = 1 after edge N.
  - Releases are visible after edge N+1.
  - Key k allocation is visible after edge N+2+k.
  - busy = 0 after edge N+5 if nothing is pending. If a frame is pending, S_REL follows directly with busy held at 1.
- voice_count and voice_active are registered from the same edge as the voice states.
- Throughput: one frame per 5 cycles.

## Configuration
- VOICE_STEAL_EN defined: with no IDLE voice, steal the RELEASE voice with the lowest gain (tie goes to the lowest index). If no voice is in RELEASE, steal the DECAY voice with the lowest gain. If neither exists, drop the key. A stolen voice gets note = key, gain = 0, state ATTACK.
- VOICE_STEAL_EN undefined: with no IDLE voice the key is dropped and voice state is unchanged.

## Test plan
- Reset, then a frame {0,0,0x3C} → after 3 cycles voice_note = 0x00003C, voice_count = 1. Gain rises 5 per tick, reaches 255 at tick 51, holds for 50 ticks, then decays to 64 and stays there.
- Key 0x3C held at gain 64, then frame {0,0,0} → state RELEASE. Gain falls 4 per tick; after 16 ticks gain = 0, voice_note = 0, voice_count = 0.
- Frame {0x40,0x40,0x3C} → voices 0 and 1 get 0x3C and 0x40; voice 2 stays idle; voice_count = 2.
- Three keys in DECAY; frame {0x50,0x3C,0x40} drops key 0x48, so 0x48 → RELEASE.
  - VOICE_STEAL_EN set: 0x50 takes the releasing voice at gain 0.
  - VOICE_STEAL_EN unset: 0x50 is dropped.
- A second frame_valid arrives 2 cycles after the first, and a third 1 cycle later → the third is processed; busy stays high for 10 cycles total.
- reset pulses during S_ALLOC1 → all outputs 0 on the following edge, and the FSM is in S_IDLE.

Source files
------------

// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
//
// Three-voice polyphonic allocator with a per-voice attack/hold/decay/release
// envelope. Each decoded key frame (three 8-bit key codes, 0 = no key) is
// processed in five cycles: one release pass, one allocation step per key,
// and one settle step. The settle step is where a pending frame is picked up.
// Envelopes advance on a shared tick from a free-running divider.
//
// Optional feature (compile-time macro VOICE_STEAL_EN):
//   defined   - with no IDLE voice a new key steals the quietest RELEASE voice,
//               or failing that the quietest DECAY voice.
//   undefined - with no IDLE voice a new key is dropped.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   frame_valid  in   one-cycle strobe, frame_keys holds a new frame
//   frame_keys   in   {key2,key1,key0}
//   busy         out  allocation FSM not idle
//   voice_note   out  {v2,v1,v0} key code per voice, 0 when idle
//   voice_gain   out  {g2,g1,g0} unsigned gain, 255 = full scale
//   voice_active out  per-voice "envelope not IDLE"
//   voice_count  out  number of active voices
// -----------------------------------------------------------------------------
module voice_scheduler #(
  parameter int TICK_DIV     = 400000,
  parameter int ATTACK_STEP  = 5,
  parameter int HOLD_TICKS   = 50,
  parameter int DECAY_STEP   = 1,
  parameter int SUSTAIN_LVL  = 64,
  parameter int RELEASE_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [23:0] frame_keys,
  output logic        busy,
  output logic [23:0] voice_note,
  output logic [23:0] voice_gain,
  output logic [2:0]  voice_active,
  output logic [1:0]  voice_count
);

  typedef enum logic [2:0] {V_IDLE, V_ATTACK, V_HOLD, V_DECAY, V_RELEASE} vstate_e;
  typedef enum logic [2:0] {S_IDLE, S_REL, S_ALLOC0, S_ALLOC1, S_ALLOC2} fsm_e;

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  // 9-bit steps so the add/subtract carry shows saturation directly.
  localparam logic [8:0] ATT9 = 9'(ATTACK_STEP);
  localparam logic [8:0] DEC9 = 9'(DECAY_STEP);
  localparam logic [8:0] REL9 = 9'(RELEASE_STEP);
  localparam logic [7:0] SUS8 = 8'(SUSTAIN_LVL);

  // ---------------------------------------------------------------------------
  // Envelope tick divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  // NOTE: sequential state is written with non-blocking (<=) assignments only,
  // so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  vstate_e           vs     [3];
  vstate_e           vs_n   [3];
  logic [7:0]        note   [3];
  logic [7:0]        note_n [3];
  logic [7:0]        gain   [3];
  logic [7:0]        gain_n [3];
  logic [HOLD_W-1:0] hold   [3];
  logic [HOLD_W-1:0] hold_n [3];

  fsm_e        state, state_n;
  logic [23:0] cur_keys, cur_n;
  logic [23:0] pend_keys, pend_n;
  logic        pend_valid, pend_valid_n;
  logic        settle, settle_n;

  function automatic logic in_keys(input logic [7:0] n, input logic [23:0] k);
    return (n == k[7:0]) || (n == k[15:8]) || (n == k[23:16]);
  endfunction

  // ---------------------------------------------------------------------------
  // Key under allocation: key k is skipped if zero or a repeat within the frame
  // ---------------------------------------------------------------------------
  logic [7:0] key;
  logic       key_skip;
  logic       alloc_en;

  // NOTE: every variable an always_comb writes gets a default on entry, so no
  // path can leave it holding its old value (which would infer a latch).
  always_comb begin
    key      = cur_keys[7:0];
    key_skip = 1'b0;
    alloc_en = 1'b0;
    case (state)
      S_ALLOC0: begin
        key      = cur_keys[7:0];
        alloc_en = 1'b1;
        key_skip = (key == 8'd0);
      end
      S_ALLOC1: begin
        key      = cur_keys[15:8];
        alloc_en = 1'b1;
        key_skip = (key == 8'd0) || (key == cur_keys[7:0]);
      end
      S_ALLOC2: begin
        key      = cur_keys[23:16];
        alloc_en = !settle;
        key_skip = (key == 8'd0) || (key == cur_keys[7:0]) || (key == cur_keys[15:8]);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state: tick update first, then FSM writes override it per voice
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [8:0] acc;
    logic [2:0] hit;
    logic [2:0] pick;
    logic       found;
`ifdef VOICE_STEAL_EN
    logic [7:0] best;
    best = '0;
`endif
    acc   = '0;
    hit   = '0;
    pick  = '0;
    found = 1'b0;

    state_n      = state;
    cur_n        = cur_keys;
    pend_n       = pend_keys;
    pend_valid_n = pend_valid;
    settle_n     = settle;
    for (int v = 0; v < 3; v++) begin
      vs_n[v]   = vs[v];
      note_n[v] = note[v];
      gain_n[v] = gain[v];
      hold_n[v] = hold[v];
    end

    // Envelope advance
    if (tick) begin
      for (int v = 0; v < 3; v++) begin
        case (vs[v])
          V_ATTACK: begin
            acc = {1'b0, gain[v]} + ATT9;
            if (acc >= 9'd255) begin
              gain_n[v] = 8'd255;
              vs_n[v]   = V_HOLD;
              hold_n[v] = '0;
            end else begin
              gain_n[v] = acc[7:0];
            end
          end
          V_HOLD: begin
            hold_n[v] = hold[v] + 1'b1;
            if (hold_n[v] == HOLD_W'(HOLD_TICKS)) vs_n[v] = V_DECAY;
          end
          V_DECAY: begin
            acc = {1'b0, gain[v]} - DEC9;
            gain_n[v] = (acc[8] || acc[7:0] < SUS8) ? SUS8 : acc[7:0];
          end
          V_RELEASE: begin
            acc = {1'b0, gain[v]} - REL9;
            if (acc[8] || acc[7:0] == 8'd0) begin
              gain_n[v] = 8'd0;
              note_n[v] = 8'd0;
              vs_n[v]   = V_IDLE;
            end else begin
              gain_n[v] = acc[7:0];
            end
          end
          default: ;
        endcase
      end
    end

    // A frame arriving while busy replaces whatever was pending.
    if (frame_valid && state != S_IDLE) begin
      pend_n       = frame_keys;
      pend_valid_n = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (frame_valid) begin
          cur_n   = frame_keys;
          state_n = S_REL;
        end
      end
      S_REL: begin
        for (int v = 0; v < 3; v++) begin
          if (vs[v] != V_IDLE && vs[v] != V_RELEASE && !in_keys(note[v], cur_keys)) begin
            vs_n[v]   = V_RELEASE;
            gain_n[v] = gain[v];
            note_n[v] = note[v];
          end
        end
        state_n = S_ALLOC0;
      end
      S_ALLOC0: state_n = S_ALLOC1;
      S_ALLOC1: state_n = S_ALLOC2;
      S_ALLOC2: begin
        if (!settle) begin
          settle_n = 1'b1;
        end else begin
          // Settle cycle: chain straight into the next frame if one is waiting;
          // a strobe landing on this very cycle is the newest frame.
          settle_n = 1'b0;
          if (frame_valid) begin
            cur_n        = frame_keys;
            pend_valid_n = 1'b0;
            state_n      = S_REL;
          end else if (pend_valid) begin
            cur_n        = pend_keys;
            pend_valid_n = 1'b0;
            state_n      = S_REL;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (alloc_en && !key_skip) begin
      for (int v = 0; v < 3; v++) begin
        if (!found && vs[v] != V_IDLE && note[v] == key) begin
          hit[v] = 1'b1;
          found  = 1'b1;
        end
      end
      if (found) begin
        // Retrigger a releasing voice from its current gain.
        for (int v = 0; v < 3; v++) begin
          if (hit[v] && vs[v] == V_RELEASE) begin
            vs_n[v]   = V_ATTACK;
            gain_n[v] = gain[v];
            note_n[v] = note[v];
            hold_n[v] = '0;
          end
        end
      end else begin
        for (int v = 0; v < 3; v++) begin
          if (!found && vs[v] == V_IDLE) begin
            pick[v] = 1'b1;
            found   = 1'b1;
          end
        end
`ifdef VOICE_STEAL_EN
        // Strict '<' keeps the lowest index on equal gains.
        if (!found) begin
          for (int v = 0; v < 3; v++) begin
            if (vs[v] == V_RELEASE && (!found || gain[v] < best)) begin
              pick    = '0;
              pick[v] = 1'b1;
              found   = 1'b1;
              best    = gain[v];
            end
          end
        end
        if (!found) begin
          for (int v = 0; v < 3; v++) begin
            if (vs[v] == V_DECAY && (!found || gain[v] < best)) begin
              pick    = '0;
              pick[v] = 1'b1;
              found   = 1'b1;
              best    = gain[v];
            end
          end
        end
`endif
        for (int v = 0; v < 3; v++) begin
          if (pick[v]) begin
            vs_n[v]   = V_ATTACK;
            note_n[v] = key;
            gain_n[v] = 8'd0;
            hold_n[v] = '0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the per-voice arrays are only three entries of flops, not RAM, so
  // they are reset explicitly; an aborted frame must leave nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_keys   <= '0;
      pend_keys  <= '0;
      pend_valid <= 1'b0;
      settle     <= 1'b0;
      for (int v = 0; v < 3; v++) begin
        vs[v]   <= V_IDLE;
        note[v] <= '0;
        gain[v] <= '0;
        hold[v] <= '0;
      end
    end else begin
      state      <= state_n;
      cur_keys   <= cur_n;
      pend_keys  <= pend_n;
      pend_valid <= pend_valid_n;
      settle     <= settle_n;
      for (int v = 0; v < 3; v++) begin
        vs[v]   <= vs_n[v];
        note[v] <= note_n[v];
        gain[v] <= gain_n[v];
        hold[v] <= hold_n[v];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy         = (state != S_IDLE);
  assign voice_note   = {note[2], note[1], note[0]};
  assign voice_gain   = {gain[2], gain[1], gain[0]};
  assign voice_active = {vs[2] != V_IDLE, vs[1] != V_IDLE, vs[0] != V_IDLE};
  assign voice_count  = {1'b0, voice_active[0]} + {1'b0, voice_active[1]}
                      + {1'b0, voice_active[2]};

endmodule

// File: tb/tb_voice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_voice_scheduler
//
// Directed bench for voice_scheduler with a short envelope tick. Expected
// values are queued with the edge at which they must hold and compared on the
// following falling clock edge.
// -----------------------------------------------------------------------------
module tb_voice_scheduler;

  localparam int TD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_valid;
  logic [23:0] frame_keys;
  logic        busy;
  logic [23:0] voice_note;
  logic [23:0] voice_gain;
  logic [2:0]  voice_active;
  logic [1:0]  voice_count;

  voice_scheduler #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_valid  (frame_valid),
    .frame_keys   (frame_keys),
    .busy         (busy),
    .voice_note   (voice_note),
    .voice_gain   (voice_gain),
    .voice_active (voice_active),
    .voice_count  (voice_count)
  );

  always #5 clk = ~clk;

  typedef enum {K_NOTE, K_GAIN, K_G2, K_ACTIVE, K_COUNT, K_BUSY} kind_e;
  typedef struct {
    string       tag;
    int          at;
    kind_e       kind;
    logic [23:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc;

  // Edges since reset release; the DUT tick divider fires on multiples of TD.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] observe(input kind_e k);
    case (k)
      K_NOTE:   return voice_note;
      K_GAIN:   return voice_gain;
      K_G2:     return {16'h0, voice_gain[23:16]};
      K_ACTIVE: return {21'h0, voice_active};
      K_COUNT:  return {22'h0, voice_count};
      default:  return {23'h0, busy};
    endcase
  endfunction

  task automatic expect_at(input string tag, input int at, input kind_e k, input logic [23:0] v);
    exp_t e;
    e.tag  = tag;
    e.at   = at;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        check((sb[i].at == cyc) ? sb[i].tag : {sb[i].tag, "_late"},
              observe(sb[i].kind), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  function automatic int tick_after(input int e);
    return (e / TD + 1) * TD;
  endfunction

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // NOTE: inputs are driven with blocking assignments on the falling edge so
  // the DUT sees them settled well before the next rising edge.
  task automatic send_frame(input logic [23:0] keys, output int n);
    frame_valid = 1'b1;
    frame_keys  = keys;
    n = cyc + 1;
    @(negedge clk);
    frame_valid = 1'b0;
    frame_keys  = '0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      check("scoreboard_drain", 24'(sb.size()), 24'd0);
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_note"},   voice_note, 24'h0);
    check({tag, "_gain"},   voice_gain, 24'h0);
    check({tag, "_active"}, {21'h0, voice_active}, 24'h0);
    check({tag, "_count"},  {22'h0, voice_count}, 24'h0);
    check({tag, "_busy"},   {23'h0, busy}, 24'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, p, a, t1, r1;

    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_keys  = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // ---- single key: attack, hold, decay to sustain --------------------------
    wait_until(20);
    send_frame(24'h00003C, n);
    a  = n + 2;
    t1 = tick_after(a);
    expect_at("a_busy_set",    n,     K_BUSY,   24'd1);
    expect_at("a_note_early",  n + 1, K_NOTE,   24'h0);
    expect_at("a_note",        n + 2, K_NOTE,   24'h00003C);
    expect_at("a_count",       n + 2, K_COUNT,  24'd1);
    expect_at("a_active",      n + 2, K_ACTIVE, 24'd1);
    expect_at("a_busy_last",   n + 4, K_BUSY,   24'd1);
    expect_at("a_busy_clear",  n + 5, K_BUSY,   24'd0);
    expect_at("a_gain_t1",     t1,               K_GAIN, 24'd5);
    expect_at("a_gain_t50",    t1 + 49  * TD,    K_GAIN, 24'd250);
    expect_at("a_gain_t51",    t1 + 50  * TD,    K_GAIN, 24'd255);
    expect_at("a_gain_t101",   t1 + 100 * TD,    K_GAIN, 24'd255);
    expect_at("a_gain_t102",   t1 + 101 * TD,    K_GAIN, 24'd254);
    expect_at("a_gain_t292",   t1 + 291 * TD,    K_GAIN, 24'd64);
    expect_at("a_gain_t300",   t1 + 299 * TD,    K_GAIN, 24'd64);
    wait_until(t1 + 299 * TD);

    // ---- key released: gain falls 4 per tick to zero --------------------------
    send_frame(24'h000000, n);
    r1 = tick_after(n + 1);
    expect_at("b_busy_clear",  n + 5,          K_BUSY,   24'd0);
    expect_at("b_gain_r1",     r1,             K_GAIN,   24'd60);
    expect_at("b_gain_r15",    r1 + 14 * TD,   K_GAIN,   24'd4);
    expect_at("b_note_r15",    r1 + 14 * TD,   K_NOTE,   24'h00003C);
    expect_at("b_gain_r16",    r1 + 15 * TD,   K_GAIN,   24'd0);
    expect_at("b_note_r16",    r1 + 15 * TD,   K_NOTE,   24'h0);
    expect_at("b_count_r16",   r1 + 15 * TD,   K_COUNT,  24'd0);
    expect_at("b_active_r16",  r1 + 15 * TD,   K_ACTIVE, 24'd0);
    wait_until(r1 + 15 * TD);
    drain();

    // ---- duplicate key in one frame, then fill all three voices --------------
    send_frame(24'h40403C, n);
    expect_at("c_note_k0",     n + 2, K_NOTE,   24'h00003C);
    expect_at("c_note_k1",     n + 3, K_NOTE,   24'h00403C);
    expect_at("c_note_dup",    n + 4, K_NOTE,   24'h00403C);
    expect_at("c_count_dup",   n + 4, K_COUNT,  24'd2);
    expect_at("c_active_dup",  n + 4, K_ACTIVE, 24'd3);
    wait_until(n + 6);
    send_frame(24'h48403C, m);
    expect_at("c_note_full",   m + 4, K_NOTE,   24'h48403C);
    expect_at("c_count_full",  m + 4, K_COUNT,  24'd3);
    expect_at("c_active_full", m + 4, K_ACTIVE, 24'd7);
    wait_until(tick_after(m + 4) + 110 * TD);

    // All three in DECAY; 0x48 is dropped from the frame and 0x50 is new.
    send_frame(24'h503C40, p);
    expect_at("d_note_rel",    p + 1, K_NOTE,   24'h48403C);
    expect_at("d_count",       p + 4, K_COUNT,  24'd3);
`ifdef VOICE_STEAL_EN
    expect_at("d_note_steal",  p + 4, K_NOTE,   24'h50403C);
    expect_at("d_g2_steal",    p + 4, K_G2,     24'd0);
    expect_at("d_g2_attack",   tick_after(p + 4), K_G2, 24'd5);
`else
    expect_at("d_note_drop",   p + 4, K_NOTE,   24'h48403C);
`endif
    drain();

    // ---- back-to-back frames: latest pending frame wins ----------------------
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_until(16);
    expect_at("e_busy_first",  17, K_BUSY,  24'd1);
    expect_at("e_note_f1",     19, K_NOTE,  24'h000011);
    expect_at("e_busy_chain",  22, K_BUSY,  24'd1);
    expect_at("e_note_f3",     24, K_NOTE,  24'h003311);
    expect_at("e_count_f3",    24, K_COUNT, 24'd2);
    expect_at("e_busy_tenth",  26, K_BUSY,  24'd1);
    expect_at("e_busy_clear",  27, K_BUSY,  24'd0);
    expect_at("e_note_no_f2",  27, K_NOTE,  24'h003311);
    expect_at("e_note_tick",   32, K_NOTE,  24'h003300);
    expect_at("e_count_tick",  32, K_COUNT, 24'd1);
    expect_at("e_gain_tick",   32, K_GAIN,  24'h000500);
    frame_valid = 1'b1;
    frame_keys  = 24'h000011;
    @(negedge clk);
    frame_valid = 1'b0;
    @(negedge clk);
    frame_valid = 1'b1;
    frame_keys  = 24'h000022;
    @(negedge clk);
    frame_keys  = 24'h000033;
    @(negedge clk);
    frame_valid = 1'b0;
    frame_keys  = '0;
    drain();

    // ---- reset in the middle of a frame --------------------------------------
    send_frame(24'h004455, n);
    expect_at("f_note_k0", n + 2, K_NOTE, 24'h003355);
    wait_until(n + 2);
    #2 reset = 1'b1;
    #1 check_all_zero("f_reset_async");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("f_after_reset");
    send_frame(24'h000066, n);
    expect_at("f_note_new",  n + 2, K_NOTE,  24'h000066);
    expect_at("f_count_new", n + 2, K_COUNT, 24'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
